// File: rtl/ysyx_22050710_sram_axi_bridge.sv
// Bridges the core's inst and data SRAM-like ports onto a single AXI4-Lite master.
// Data requests take priority; one transaction is in flight at a time.
module ysyx_22050710_sram_axi_bridge #(
   parameter int unsigned SRAM_ADDR_WD  = 32,
   parameter int unsigned SRAM_DATA_WD  = 64,
   parameter int unsigned SRAM_WMASK_WD = 8
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   // inst SRAM-like slave
   input  logic                     i_inst_sram_req,
   input  logic                     i_inst_sram_op,
   input  logic [1:0]               i_inst_sram_size,
   input  logic [SRAM_ADDR_WD-1:0]  i_inst_sram_addr,
   input  logic [SRAM_WMASK_WD-1:0] i_inst_sram_wstrb,
   input  logic [SRAM_DATA_WD-1:0]  i_inst_sram_wdata,
   output logic                     o_inst_sram_addr_ok,
   output logic                     o_inst_sram_data_ok,
   output logic [SRAM_DATA_WD-1:0]  o_inst_sram_rdata,
   // data SRAM-like slave
   input  logic                     i_data_sram_req,
   input  logic                     i_data_sram_op,
   input  logic [1:0]               i_data_sram_size,
   input  logic [SRAM_ADDR_WD-1:0]  i_data_sram_addr,
   input  logic [SRAM_WMASK_WD-1:0] i_data_sram_wstrb,
   input  logic [SRAM_DATA_WD-1:0]  i_data_sram_wdata,
   output logic                     o_data_sram_addr_ok,
   output logic                     o_data_sram_data_ok,
   output logic [SRAM_DATA_WD-1:0]  o_data_sram_rdata,
   // AXI read address / data
   output logic [SRAM_ADDR_WD-1:0]  o_axi_araddr,
   output logic [2:0]               o_axi_arsize,
   output logic                     o_axi_arvalid,
   input  logic                     i_axi_arready,
   input  logic [SRAM_DATA_WD-1:0]  i_axi_rdata,
   input  logic [1:0]               i_axi_rresp,
   input  logic                     i_axi_rvalid,
   output logic                     o_axi_rready,
   // AXI write address / data / response
   output logic [SRAM_ADDR_WD-1:0]  o_axi_awaddr,
   output logic [2:0]               o_axi_awsize,
   output logic                     o_axi_awvalid,
   input  logic                     i_axi_awready,
   output logic [SRAM_DATA_WD-1:0]  o_axi_wdata,
   output logic [SRAM_WMASK_WD-1:0] o_axi_wstrb,
   output logic                     o_axi_wvalid,
   input  logic                     i_axi_wready,
   input  logic [1:0]               i_axi_bresp,
   input  logic                     i_axi_bvalid,
   output logic                     o_axi_bready,
   output logic                     o_bus_err
);

   typedef enum logic [2:0] {IDLE, RADDR, RDATA, WREQ, WRESP} state_t;

   state_t                   r_state;
   logic [SRAM_ADDR_WD-1:0]  r_addr;
   logic [1:0]               r_size;
   logic [SRAM_WMASK_WD-1:0] r_wstrb;
   logic [SRAM_DATA_WD-1:0]  r_wdata;
   logic                     r_owner_data;
   logic                     r_aw_done;
   logic                     r_w_done;

   logic w_idle;
   logic w_grant_data;
   logic w_grant_inst;
   logic w_aw_hs;
   logic w_w_hs;
   logic w_aw_fin;
   logic w_w_fin;
   logic w_r_fin;
   logic w_b_fin;
   logic w_unused;

   // Write-side inputs of the inst port carry no meaning: every inst access is a read.
   assign w_unused = ^{i_inst_sram_op, i_inst_sram_wstrb, i_inst_sram_wdata};

   assign w_idle       = (r_state == IDLE) & i_rst_n;
   assign w_grant_data = w_idle & i_data_sram_req;
   assign w_grant_inst = w_idle & ~i_data_sram_req & i_inst_sram_req;

   assign w_aw_hs  = o_axi_awvalid & i_axi_awready;
   assign w_w_hs   = o_axi_wvalid & i_axi_wready;
   assign w_aw_fin = r_aw_done | w_aw_hs;
   assign w_w_fin  = r_w_done | w_w_hs;
   assign w_r_fin  = (r_state == RDATA) & i_axi_rvalid;
   assign w_b_fin  = (r_state == WRESP) & i_axi_bvalid;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= IDLE;
         r_addr       <= '0;
         r_size       <= '0;
         r_wstrb      <= '0;
         r_wdata      <= '0;
         r_owner_data <= 1'b0;
         r_aw_done    <= 1'b0;
         r_w_done     <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_grant_data) begin
                  r_addr       <= i_data_sram_addr;
                  r_size       <= i_data_sram_size;
                  r_wstrb      <= i_data_sram_wstrb;
                  r_wdata      <= i_data_sram_wdata;
                  r_owner_data <= 1'b1;
                  r_state      <= i_data_sram_op ? WREQ : RADDR;
               end else if (w_grant_inst) begin
                  r_addr       <= i_inst_sram_addr;
                  r_size       <= i_inst_sram_size;
                  r_owner_data <= 1'b0;
                  r_state      <= RADDR;
               end
            end
            RADDR: if (i_axi_arready) r_state <= RDATA;
            RDATA: if (i_axi_rvalid)  r_state <= IDLE;
            WREQ: begin
               // AW and W may complete in either order or together.
               if (w_aw_fin && w_w_fin) begin
                  r_aw_done <= 1'b0;
                  r_w_done  <= 1'b0;
                  r_state   <= WRESP;
               end else begin
                  if (w_aw_hs) r_aw_done <= 1'b1;
                  if (w_w_hs)  r_w_done  <= 1'b1;
               end
            end
            WRESP: if (i_axi_bvalid) r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_inst_sram_addr_ok = w_grant_inst;
   assign o_data_sram_addr_ok = w_grant_data;
   assign o_inst_sram_data_ok = w_r_fin & ~r_owner_data;
   assign o_data_sram_data_ok = (w_r_fin & r_owner_data) | w_b_fin;
   assign o_inst_sram_rdata   = (w_r_fin & ~r_owner_data) ? i_axi_rdata : '0;
   assign o_data_sram_rdata   = (w_r_fin & r_owner_data) ? i_axi_rdata : '0;

   assign o_axi_araddr  = r_addr;
   assign o_axi_arsize  = {1'b0, r_size};
   assign o_axi_arvalid = (r_state == RADDR);
   assign o_axi_rready  = (r_state == RDATA);

   assign o_axi_awaddr  = r_addr;
   assign o_axi_awsize  = {1'b0, r_size};
   assign o_axi_awvalid = (r_state == WREQ) & ~r_aw_done;
   assign o_axi_wdata   = r_wdata;
   assign o_axi_wstrb   = r_wstrb;
   assign o_axi_wvalid  = (r_state == WREQ) & ~r_w_done;
   assign o_axi_bready  = (r_state == WRESP);

   assign o_bus_err = (w_r_fin & (i_axi_rresp != 2'b00)) | (w_b_fin & (i_axi_bresp != 2'b00));

endmodule

// File: tb/tb_ysyx_22050710_sram_axi_bridge.sv
// Directed bench for the SRAM-like to AXI4-Lite bridge: vector table plus
// hand-written arbitration and mid-transaction reset sequences.
module tb_ysyx_22050710_sram_axi_bridge;

   logic        clk = 1'b0;
   logic        rst_n;
   always #5 clk = ~clk;

   logic        inst_req, inst_op, data_req, data_op;
   logic [1:0]  inst_size, data_size;
   logic [31:0] inst_addr, data_addr;
   logic [7:0]  inst_wstrb, data_wstrb;
   logic [63:0] inst_wdata, data_wdata;
   logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
   logic [63:0] inst_rdata, data_rdata;
   logic [31:0] araddr, awaddr;
   logic [2:0]  arsize, awsize;
   logic        arvalid, arready, rvalid, rready;
   logic [63:0] rdata, wdata;
   logic [1:0]  rresp, bresp;
   logic        awvalid, awready, wvalid, wready, bvalid, bready, bus_err;
   logic [7:0]  wstrb;

   ysyx_22050710_sram_axi_bridge dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_inst_sram_req(inst_req), .i_inst_sram_op(inst_op), .i_inst_sram_size(inst_size),
      .i_inst_sram_addr(inst_addr), .i_inst_sram_wstrb(inst_wstrb), .i_inst_sram_wdata(inst_wdata),
      .o_inst_sram_addr_ok(inst_addr_ok), .o_inst_sram_data_ok(inst_data_ok), .o_inst_sram_rdata(inst_rdata),
      .i_data_sram_req(data_req), .i_data_sram_op(data_op), .i_data_sram_size(data_size),
      .i_data_sram_addr(data_addr), .i_data_sram_wstrb(data_wstrb), .i_data_sram_wdata(data_wdata),
      .o_data_sram_addr_ok(data_addr_ok), .o_data_sram_data_ok(data_data_ok), .o_data_sram_rdata(data_rdata),
      .o_axi_araddr(araddr), .o_axi_arsize(arsize), .o_axi_arvalid(arvalid), .i_axi_arready(arready),
      .i_axi_rdata(rdata), .i_axi_rresp(rresp), .i_axi_rvalid(rvalid), .o_axi_rready(rready),
      .o_axi_awaddr(awaddr), .o_axi_awsize(awsize), .o_axi_awvalid(awvalid), .i_axi_awready(awready),
      .o_axi_wdata(wdata), .o_axi_wstrb(wstrb), .o_axi_wvalid(wvalid), .i_axi_wready(wready),
      .i_axi_bresp(bresp), .i_axi_bvalid(bvalid), .o_axi_bready(bready),
      .o_bus_err(bus_err)
   );

   typedef struct {
      logic        is_data;
      logic        op;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [63:0] wd;
      logic [7:0]  ws;
      logic [63:0] rd;
      logic [1:0]  resp;
      int          ar_wait;
      int          r_wait;
      int          aw_wait;
      int          w_wait;
      int          b_wait;
      logic [63:0] exp_rdata;
      int          exp_err;
      int          exp_lat;
   } vec_t;

   vec_t vecs[10];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic clear_slave();
      arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0;
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = '0;
   endtask

   // Drives one request on the chosen port and plays a slave with the vector's wait states.
   task automatic run_vec(input int idx, input vec_t v);
      int   ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
      int   ar_hs, aw_hs, w_beats, err_pulses, other_ok, rd_bad, done_cyc;
      logic is_wr, own_ok, oth_ok;
      logic [63:0] own_rd;
      ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
      ar_hs = 0; aw_hs = 0; w_beats = 0; err_pulses = 0; other_ok = 0; rd_bad = 0; done_cyc = -1;
      is_wr = v.is_data & v.op;
      @(negedge clk);
      if (v.is_data) begin
         data_req = 1'b1; data_op = v.op; data_size = v.size; data_addr = v.addr;
         data_wdata = v.wd; data_wstrb = v.ws;
      end else begin
         inst_req = 1'b1; inst_op = v.op; inst_size = v.size; inst_addr = v.addr;
         inst_wdata = v.wd; inst_wstrb = v.ws;
      end
      for (int cyc = 0; cyc < 60; cyc++) begin
         if (cyc > 0) @(negedge clk);
         if (cyc == 1) begin
            inst_req = 1'b0; data_req = 1'b0;
            inst_addr = ~v.addr; data_addr = ~v.addr; data_size = ~v.size; inst_size = ~v.size;
            data_wdata = ~v.wd; data_wstrb = ~v.ws;
         end
         arready = arvalid && (ar_cnt >= v.ar_wait);
         rvalid  = rready && (r_cnt >= v.r_wait);
         rdata   = rvalid ? v.rd : 64'h0;
         rresp   = v.resp;
         awready = awvalid && (aw_cnt >= v.aw_wait);
         wready  = wvalid && (w_cnt >= v.w_wait);
         bvalid  = bready && (b_cnt >= v.b_wait);
         bresp   = v.resp;
         if (arvalid) begin
            check($sformatf("v%0d araddr", idx), araddr, v.addr);
            check($sformatf("v%0d arsize", idx), arsize, {1'b0, v.size});
            ar_cnt++;
            if (arready) ar_hs++;
         end
         if (rready) r_cnt++;
         if (awvalid) begin
            check($sformatf("v%0d awaddr", idx), awaddr, v.addr);
            check($sformatf("v%0d awsize", idx), awsize, {1'b0, v.size});
            aw_cnt++;
            if (awready) aw_hs++;
         end
         if (wvalid) begin
            check($sformatf("v%0d wdata", idx), wdata, v.wd);
            check($sformatf("v%0d wstrb", idx), wstrb, v.ws);
            w_cnt++;
            if (wready) w_beats++;
         end
         if (bready) b_cnt++;
         #1;
         if (cyc == 0) begin
            check($sformatf("v%0d addr_ok", idx), v.is_data ? data_addr_ok : inst_addr_ok, 1'b1);
            check($sformatf("v%0d other_addr_ok", idx), v.is_data ? inst_addr_ok : data_addr_ok, 1'b0);
         end
         own_ok = v.is_data ? data_data_ok : inst_data_ok;
         oth_ok = v.is_data ? inst_data_ok : data_data_ok;
         own_rd = v.is_data ? data_rdata : inst_rdata;
         if (oth_ok) other_ok++;
         if (bus_err) err_pulses++;
         if (!inst_data_ok && inst_rdata != 64'h0) rd_bad++;
         if (!data_data_ok && data_rdata != 64'h0) rd_bad++;
         if (own_ok) begin
            check($sformatf("v%0d rdata", idx), own_rd, v.exp_rdata);
            done_cyc = cyc;
            break;
         end
      end
      check($sformatf("v%0d latency", idx), 64'(done_cyc), 64'(v.exp_lat));
      check($sformatf("v%0d bus_err pulses", idx), 64'(err_pulses), 64'(v.exp_err));
      check($sformatf("v%0d other data_ok", idx), 64'(other_ok), 64'h0);
      check($sformatf("v%0d rdata idle zero", idx), 64'(rd_bad), 64'h0);
      check($sformatf("v%0d ar handshakes", idx), 64'(ar_hs), is_wr ? 64'h0 : 64'h1);
      check($sformatf("v%0d aw handshakes", idx), 64'(aw_hs), is_wr ? 64'h1 : 64'h0);
      check($sformatf("v%0d w beats", idx), 64'(w_beats), is_wr ? 64'h1 : 64'h0);
      @(negedge clk);
      clear_slave();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      //            dat op sz  addr           wdata                  wstrb  rdata                   resp   arw rw aww ww bw exp_rdata              err lat
      vecs[0] = '{1'b0,1'b0,2'd2,32'h8000_0000,64'h0,                8'h00,64'h13,                 2'b00, 0,0,0,0,0, 64'h13,                 0, 2};
      vecs[1] = '{1'b1,1'b0,2'd3,32'h8000_1000,64'h0,                8'h00,64'h1122_3344_5566_7788,2'b00, 0,0,0,0,0, 64'h1122_3344_5566_7788,0, 2};
      vecs[2] = '{1'b1,1'b1,2'd2,32'h8000_2000,64'hDEAD_BEEF,        8'h0F,64'h0,                  2'b00, 0,0,2,0,0, 64'h0,                  0, 4};
      vecs[3] = '{1'b1,1'b0,2'd3,32'h8000_3000,64'h0,                8'h00,64'hCAFE,               2'b00, 5,0,0,0,0, 64'hCAFE,               0, 7};
      vecs[4] = '{1'b1,1'b0,2'd3,32'h8000_4000,64'h0,                8'h00,64'h55,                 2'b10, 0,0,0,0,0, 64'h55,                 1, 2};
      vecs[5] = '{1'b1,1'b1,2'd3,32'h8000_5000,64'h0123_4567_89AB_CDEF,8'hFF,64'h0,                2'b11, 0,0,0,3,0, 64'h0,                  1, 5};
      vecs[6] = '{1'b0,1'b1,2'd2,32'h8000_0008,64'hFFFF,             8'hFF,64'h6F,                 2'b00, 0,0,0,0,0, 64'h6F,                 0, 2};
      vecs[7] = '{1'b1,1'b0,2'd1,32'h8000_6002,64'h0,                8'h00,64'hBEEF_0000,          2'b00, 0,2,0,0,0, 64'hBEEF_0000,          0, 4};
      vecs[8] = '{1'b1,1'b1,2'd3,32'h8000_7000,64'hAAAA,             8'hF0,64'h0,                  2'b00, 0,0,1,1,1, 64'h0,                  0, 4};
      vecs[9] = '{1'b0,1'b0,2'd0,32'h8000_0003,64'h0,                8'h00,64'h7,                  2'b01, 0,0,0,0,0, 64'h7,                  1, 2};

      // Reset state, with both requests high to expose any ungated grant.
      rst_n = 1'b0;
      inst_req = 1'b1; inst_op = 1'b0; inst_size = 2'd2; inst_addr = 32'h8000_0000;
      inst_wstrb = '0; inst_wdata = '0;
      data_req = 1'b1; data_op = 1'b0; data_size = 2'd2; data_addr = 32'h8000_1000;
      data_wstrb = '0; data_wdata = '0;
      clear_slave();
      #12;
      check("reset inst_addr_ok", inst_addr_ok, 1'b0);
      check("reset data_addr_ok", data_addr_ok, 1'b0);
      check("reset valids", {arvalid, rready, awvalid, wvalid, bready}, 5'b0);
      check("reset data_ok", {inst_data_ok, data_data_ok, bus_err}, 3'b0);
      inst_req = 1'b0; data_req = 1'b0;
      @(negedge clk); rst_n = 1'b1;

      for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

      // Simultaneous requests: data is served first, inst only after data completes.
      @(negedge clk);
      data_req = 1'b1; data_op = 1'b0; data_size = 2'd3; data_addr = 32'h8000_1000;
      inst_req = 1'b1; inst_op = 1'b0; inst_size = 2'd2; inst_addr = 32'h8000_0004;
      #1;
      check("arb data addr_ok", data_addr_ok, 1'b1);
      check("arb inst blocked c0", inst_addr_ok, 1'b0);
      @(negedge clk); data_req = 1'b0; data_addr = '0; arready = 1'b1; #1;
      check("arb inst blocked c1", inst_addr_ok, 1'b0);
      check("arb first araddr", araddr, 32'h8000_1000);
      check("arb first arvalid", arvalid, 1'b1);
      @(negedge clk); arready = 1'b0; rvalid = 1'b1; rdata = 64'hA5; #1;
      check("arb data data_ok", data_data_ok, 1'b1);
      check("arb data rdata", data_rdata, 64'hA5);
      check("arb inst blocked c2", inst_addr_ok, 1'b0);
      check("arb inst data_ok c2", inst_data_ok, 1'b0);
      @(negedge clk); rvalid = 1'b0; rdata = '0; #1;
      check("arb inst addr_ok c3", inst_addr_ok, 1'b1);
      @(negedge clk); inst_req = 1'b0; arready = 1'b1; #1;
      check("arb second araddr", araddr, 32'h8000_0004);
      check("arb second arsize", arsize, 3'b010);
      @(negedge clk); arready = 1'b0; rvalid = 1'b1; rdata = 64'h13; #1;
      check("arb inst data_ok", inst_data_ok, 1'b1);
      check("arb inst rdata", inst_rdata, 64'h13);
      check("arb data data_ok quiet", data_data_ok, 1'b0);
      @(negedge clk); clear_slave();

      // Asynchronous reset while waiting in the read-data phase.
      @(negedge clk);
      inst_req = 1'b1; inst_addr = 32'h8000_0000; inst_size = 2'd2;
      @(negedge clk); inst_req = 1'b0; arready = 1'b1;
      @(negedge clk); arready = 1'b0; #1;
      check("rst pre rready", rready, 1'b1);
      #1; rst_n = 1'b0; rvalid = 1'b1; rdata = 64'h99; inst_req = 1'b1; data_req = 1'b1; #1;
      check("rst rready", rready, 1'b0);
      check("rst inst data_ok", inst_data_ok, 1'b0);
      check("rst inst rdata", inst_rdata, 64'h0);
      check("rst addr_ok", {inst_addr_ok, data_addr_ok}, 2'b00);
      check("rst valids", {arvalid, awvalid, wvalid, bready, bus_err}, 5'b0);
      @(negedge clk); inst_req = 1'b0; data_req = 1'b0; clear_slave();
      @(negedge clk); rst_n = 1'b1;
      run_vec(10, vecs[0]);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
